// File: rtl/reduce_tree_pipe.sv
// Reduces a WIDTH-bit vector to one bit (OR/AND/XOR/NOR chosen per beat) through a balanced 2-input tree.
// Latency: LEVELS = $clog2(WIDTH) cycles, one register per tree level; sustains one beat per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready in the same cycle.
module reduce_tree_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_data,
  output logic [1:0]       out_mode
);

  // Tree depth is derived from WIDTH so it can never disagree with it.
  localparam int LEVELS = $clog2(WIDTH);
  // All stages laid end to end: stage 0 (WIDTH bits) .. stage LEVELS (1 bit).
  localparam int TREE_W = 2 * WIDTH - 1;

  localparam logic [1:0] MODE_AND = 2'b01;
  localparam logic [1:0] MODE_XOR = 2'b10;
  localparam logic [1:0] MODE_NOR = 2'b11;

  typedef struct packed {
    logic       vld;
    logic [1:0] mode;
  } meta_t;

  // Stage k partial bits live at offset 2*WIDTH - 2*(WIDTH>>k).
  wire [TREE_W-1:0]         tree_dat;
  // Stage k metadata (valid + mode) lives at bits [3k +: 3].
  wire [3*(LEVELS+1)-1:0]   meta_bus;
  logic                     adv;

  assign tree_dat[WIDTH-1:0] = in_data;
  assign meta_bus[2:0]       = {in_valid, in_mode};

  // The last stage is the output register; nothing sits behind it.
  assign out_valid = meta_bus[3*LEVELS+2];
  assign out_mode  = meta_bus[3*LEVELS +: 2];
  assign out_data  = tree_dat[TREE_W-1];

  // Whole pipe moves together: bubbles advance too, they are never squeezed out.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int NW  = WIDTH >> k;
    localparam int SRC = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
    localparam int DST = 2 * WIDTH - 2 * NW;

    logic [2*NW-1:0] src_part;
    meta_t           src_meta;
    logic [NW-1:0]   pair_d;
    logic [NW-1:0]   part_q;
    meta_t           meta_q;

    assign src_part = tree_dat[SRC +: 2*NW];
    assign src_meta = meta_bus[3*(k-1) +: 3];

    // Pairwise operator; NOR reduces as OR and flips only the single final bit.
    always_comb begin
      pair_d = '0;
      for (int i = 0; i < NW; i++) begin
        case (src_meta.mode)
          MODE_AND: pair_d[i] = src_part[2*i] & src_part[2*i+1];
          MODE_XOR: pair_d[i] = src_part[2*i] ^ src_part[2*i+1];
          default:  pair_d[i] = src_part[2*i] | src_part[2*i+1];
        endcase
      end
      if (k == LEVELS && src_meta.mode == MODE_NOR) begin
        pair_d[0] = ~pair_d[0];
      end
    end

    // Stage register: loads from the previous stage on adv, otherwise holds; reset flushes in-flight beats.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        part_q <= '0;
        meta_q <= '0;
      end else if (adv) begin
        part_q <= pair_d;
        meta_q <= src_meta;
      end
    end

    assign tree_dat[DST +: NW]  = part_q;
    assign meta_bus[3*k +: 3]   = meta_q;
  end

  // A stalled result must stay put until the consumer takes it.
  a_stall_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_mode)));

endmodule

// File: tb/tb_reduce_tree_pipe.sv
// Bench for reduce_tree_pipe at WIDTH 8, 2 and 32.
// Latency: checked per result against the tree depth whenever the sink never stalls.
// Backpressure: hand-written stall sequence plus random out_ready on all three instances.
module tb_reduce_tree_pipe;

  typedef struct {
    logic [7:0] d;
    logic [1:0] m;
    logic       e;
  } vec_t;

  typedef struct {
    logic       d;
    logic [1:0] m;
    int         c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv8, ir8, ov8, or8, od8;
  logic [7:0]  id8;
  logic [1:0]  im8, om8;
  logic        iv2, ir2, ov2, or2, od2;
  logic [1:0]  id2;
  logic [1:0]  im2, om2;
  logic        iv32, ir32, ov32, or32, od32;
  logic [31:0] id32;
  logic [1:0]  im32, om32;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  bit   chk_lat = 1'b0;
  bit   acc8;
  exp_t q8[$];
  exp_t q2[$];
  exp_t q32[$];

  always #5 clk = ~clk;

  reduce_tree_pipe #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_mode(im8),
    .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_mode(om8));

  reduce_tree_pipe #(.WIDTH(2)) u_w2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_mode(im2),
    .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_mode(om2));

  reduce_tree_pipe #(.WIDTH(32)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .in_data(id32), .in_mode(im32),
    .out_valid(ov32), .out_ready(or32), .out_data(od32), .out_mode(om32));

  // Reference: whole-vector reduction of the low w bits.
  function automatic logic model(input logic [31:0] d, input int w, input logic [1:0] m);
    logic [31:0] msk;
    msk = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case (m)
      2'b00:   return |(d & msk);
      2'b01:   return &(d | ~msk);
      2'b10:   return ^(d & msk);
      default: return ~|(d & msk);
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic take_chk(input string nm, input int lvl, input bit have, input exp_t e,
                          input logic od, input logic [1:0] om);
    if (!have) begin
      n_chk++;
      n_err++;
      $display("FAIL %s_extra: got result data=%0b mode=%0d expected no result (cycle %0d)", nm, od, om, cyc);
    end else begin
      check({nm, "_data"}, 32'(od), 32'(e.d));
      check({nm, "_mode"}, 32'(om), 32'(e.m));
      if (chk_lat) check({nm, "_latency"}, cyc - e.c, lvl);
    end
  endtask

  // One clock: drive at the falling edge, judge handshakes 1ns later, move to the next falling edge.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] m,
                      input logic rdy, input logic ex);
    exp_t e;
    bit   have;
    iv8 = v; id8 = d; im8 = m; or8 = rdy;
    #1;
    acc8 = iv8 && ir8;
    if (ov8 && !or8) begin
      check("stall_in_ready", 32'(ir8), 32'd0);
      if (q8.size() > 0) begin
        check("stall_data", 32'(od8), 32'(q8[0].d));
        check("stall_mode", 32'(om8), 32'(q8[0].m));
      end
    end
    if (ov8 && or8) begin
      have = q8.size() > 0;
      if (have) e = q8.pop_front();
      take_chk("w8", 3, have, e, od8, om8);
    end
    if (ov2 && or2) begin
      have = q2.size() > 0;
      if (have) e = q2.pop_front();
      take_chk("w2", 1, have, e, od2, om2);
    end
    if (ov32 && or32) begin
      have = q32.size() > 0;
      if (have) e = q32.pop_front();
      take_chk("w32", 5, have, e, od32, om32);
    end
    if (acc8)         q8.push_back('{d: ex, m: m, c: cyc});
    if (iv2 && ir2)   q2.push_back('{d: model(32'(id2), 2, im2), m: im2, c: cyc});
    if (iv32 && ir32) q32.push_back('{d: model(id32, 32, im32), m: im32, c: cyc});
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    iv2 = 1'b0; or2 = 1'b1; iv32 = 1'b0; or32 = 1'b1;
    step(1'b0, 8'h00, 2'b00, 1'b1, 1'b0);
  endtask

  task automatic rand_all(input bit rnd_rdy);
    logic [7:0] d;
    logic [1:0] m;
    logic       v, r;
    iv2  = ($urandom_range(9) < 7); id2  = 2'($urandom); im2  = 2'($urandom);
    or2  = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
    iv32 = ($urandom_range(9) < 7); id32 = $urandom;     im32 = 2'($urandom);
    or32 = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
    d = 8'($urandom); m = 2'($urandom);
    v = ($urandom_range(9) < 7);
    r = rnd_rdy ? ($urandom_range(3) != 0) : 1'b1;
    step(v, d, m, r, model(32'(d), 8, m));
  endtask

  vec_t tbl[12];
  vec_t strm[5];

  initial begin
    int         sent;
    int         stalled;
    logic       rdy;
    logic [2:0] pat;

    tbl[0]  = '{8'h00, 2'b00, 1'b0};
    tbl[1]  = '{8'h10, 2'b00, 1'b1};
    tbl[2]  = '{8'hFF, 2'b01, 1'b1};
    tbl[3]  = '{8'hFE, 2'b01, 1'b0};
    tbl[4]  = '{8'h07, 2'b10, 1'b1};
    tbl[5]  = '{8'h03, 2'b10, 1'b0};
    tbl[6]  = '{8'h00, 2'b11, 1'b1};
    tbl[7]  = '{8'h80, 2'b11, 1'b0};
    tbl[8]  = '{8'h80, 2'b00, 1'b1};
    tbl[9]  = '{8'h01, 2'b01, 1'b0};
    tbl[10] = '{8'hFF, 2'b10, 1'b0};
    tbl[11] = '{8'hFF, 2'b11, 1'b0};
    strm[0] = '{8'hF0, 2'b00, 1'b1};
    strm[1] = '{8'h0F, 2'b01, 1'b0};
    strm[2] = '{8'h55, 2'b10, 1'b0};
    strm[3] = '{8'h01, 2'b10, 1'b1};
    strm[4] = '{8'h00, 2'b11, 1'b1};

    rst = 1'b1;
    iv8 = 1'b0; id8 = '0; im8 = '0; or8 = 1'b1;
    iv2 = 1'b0; id2 = '0; im2 = '0; or2 = 1'b1;
    iv32 = 1'b0; id32 = '0; im32 = '0; or32 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(ov8), 32'd0);
    check("rst_out_data", 32'(od8), 32'd0);
    check("rst_out_mode", 32'(om8), 32'd0);
    check("rst_in_ready", 32'(ir8), 32'd1);
    check("rst_w2_valid", 32'(ov2), 32'd0);
    check("rst_w32_valid", 32'(ov32), 32'd0);
    rst = 1'b0;

    // Basic OR plus every operator, back to back, fixed latency expected.
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) step(1'b1, tbl[i].d, tbl[i].m, 1'b1, tbl[i].e);
    repeat (6) idle();
    check("table_drained", q8.size(), 0);

    // Stall: out_ready low for 4 cycles once the first result shows up.
    chk_lat = 1'b0;
    sent = 0;
    stalled = 0;
    for (int c = 0; c < 40; c++) begin
      if (sent == 5 && q8.size() == 0) break;
      rdy = 1'b1;
      if (ov8 && stalled < 4) begin
        rdy = 1'b0;
        stalled++;
      end
      if (sent < 5) step(1'b1, strm[sent].d, strm[sent].m, rdy, strm[sent].e);
      else          step(1'b0, 8'h00, 2'b00, rdy, 1'b0);
      if (acc8) sent++;
    end
    check("stall_cycles", stalled, 4);
    check("stall_sent", sent, 5);
    check("stall_drained", q8.size(), 0);

    // Bubbles: 1,0,1 in gives 1,0,1 out three cycles later.
    chk_lat = 1'b1;
    step(1'b1, 8'h04, 2'b10, 1'b1, 1'b1);
    step(1'b0, 8'hFF, 2'b01, 1'b1, 1'b0);
    step(1'b1, 8'h00, 2'b11, 1'b1, 1'b1);
    pat = '0;
    for (int j = 0; j < 3; j++) begin
      pat = {pat[1:0], ov8};
      idle();
    end
    check("bubble_pattern", 32'(pat), 32'b101);
    repeat (3) idle();

    // Reset with three beats in flight.
    step(1'b1, 8'hFF, 2'b01, 1'b1, 1'b1);
    step(1'b1, 8'h0F, 2'b00, 1'b1, 1'b1);
    step(1'b1, 8'h3C, 2'b11, 1'b1, 1'b0);
    check("t5_pre_valid", 32'(ov8), 32'd1);
    rst = 1'b1;
    iv8 = 1'b0;
    #1;
    check("t5_out_valid", 32'(ov8), 32'd0);
    check("t5_out_data", 32'(od8), 32'd0);
    check("t5_out_mode", 32'(om8), 32'd0);
    check("t5_in_ready", 32'(ir8), 32'd1);
    q8.delete();
    @(negedge clk);
    cyc++;
    rst = 1'b0;
    step(1'b1, 8'h01, 2'b10, 1'b1, 1'b1);
    repeat (8) idle();
    check("t5_drained", q8.size(), 0);

    // Random vectors on all widths: never-stalling sink first, then random backpressure.
    chk_lat = 1'b1;
    repeat (150) rand_all(1'b0);
    chk_lat = 1'b0;
    repeat (400) rand_all(1'b1);
    repeat (10) idle();
    check("rand_w8_drained", q8.size(), 0);
    check("rand_w2_drained", q2.size(), 0);
    check("rand_w32_drained", q32.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
